csr_access_unit: RTL and testbench
==================================

// Module: csr_access_unit
// PURPOSE
//  Pipeline-side producer of the CSR write packet. Accepts one CSR/SYSTEM instruction.
//  Reads the old CSR value and computes the read-modify-write result (CSRRW/S/C, imm forms).
//  Publishes the write packet consumed by the CSR register file, then returns old value for rd.
//  One instruction in flight; sits between execute and writeback.
// PARAMETERS
//  XLEN        64   data width of CSR values, rs1 value, pc, rd data
//  CNT_W       64   width of wr_inst_counter
// PORTS
//  clk              in   1      clock
//  rst              in   1      reset, asynchronous, active-high
//  req_valid        in   1      request present
//  req_ready        out  1      unit can accept (IDLE only)
//  req_funct3       in   3      001 RW,010 RS,011 RC,101 RWI,110 RSI,111 RCI,000 SYSTEM
//  req_sys          in   2      when funct3=000: 01 ECALL, 10 MRET, else no-op
//  req_addr         in   12     CSR address
//  req_rs1_val      in   XLEN   rs1 register value (register forms)
//  req_rs1_idx      in   5      rs1 index / zimm (imm forms, zero-extended source)
//  req_pc           in   XLEN   instruction pc
//  csr_raddr        out  12     read address to CSR file (combinational read mux)
//  csr_rdata        in   XLEN   CSR file read data, valid same cycle as csr_raddr
//  resp_valid       out  1      rd result available
//  resp_ready       in   1      consumer takes result
//  resp_rd_data     out  XLEN   old CSR value (0 for SYSTEM)
//  resp_illegal     out  1      illegal-access flag (see CONFIGURATION)
//  wr_inst_counter  out  CNT_W  increments once per committed instruction
//  wr_csr_write_enable out 1    CSR write requested
//  wr_plain         out  1      1 for CSR-op packets, 0 for SYSTEM packets
//  wr_csr_dest_addr out  12     write address
//  wr_csr_write_data out XLEN   new value
//  wr_ecall/wr_mret out  1 each SYSTEM event flags
//  wr_pc            out  XLEN   pc of committed instruction
// BEHAVIOUR
//  Reset: all outputs 0, req_ready=1 after release, FSM=IDLE; in-flight op is dropped.
//  FSM: IDLE -(req_valid)-> READ -> COMMIT -> RESP -(resp_ready)-> IDLE.
//  IDLE: req_ready=1; on req_valid&req_ready latch all req_* fields (cycle 0).
//  READ (cycle 1): csr_raddr=latched addr; capture csr_rdata as old. csr_raddr=0 elsewhere.
//  COMMIT (cycle 2 edge): load all wr_* fields and increment wr_inst_counter by 1, same edge.
//   wr_* fields then hold until the next COMMIT (file samples after counter change).
//  RESP (cycle 3+): resp_valid=1, resp_rd_data stable until resp_ready sampled high.
//   resp_valid&resp_ready -> IDLE next edge; req_ready low in RESP (no overlap).
//  src = register forms req_rs1_val, imm forms {59'b0,zimm}.
//  RW/RWI: enable=1, data=src. RS/RSI: data=old|src. RC/RCI: data=old&~src.
//  RS/RC/RSI/RCI with rs1_idx==0: enable=0, data=old; counter still increments.
//  SYSTEM ECALL: wr_ecall=1, enable=0, plain=0, wr_pc=req_pc; MRET: wr_mret=1, same.
//  SYSTEM other: all flags 0, plain=0, counter increments (no-op commit).
//  CSR ops: plain=1, ecall=mret=0, wr_pc=req_pc.
//  Counter wraps modulo 2^CNT_W; only inequality with previous value matters.
//  Latency accept->resp_valid: 3 cycles; throughput max 1 op per 4 cycles.
// CONFIGURATION
//  CSR_ILLEGAL_TRAP_EN defined: write intent to addr[11:10]==2'b11 is illegal.
//   Write intent = RW/RWI always; RS/RC forms with rs1_idx!=0.
//   Illegal: resp_illegal=1, enable=0, rd_data=0; counter still increments.
//  Undefined: resp_illegal tied 0; write issued unchanged.
// TESTING
//  reset mid-READ -> next cycle all outputs 0, req_ready=1, counter=0
//  CSRRW 0x340 rs1=0xDEAD, csrfile old=0x5 -> write 0xDEAD en=1 plain=1, rd=0x5, counter 0->1
//  CSRRS 0x300 old=0x8 rs1_idx=0 -> en=0, rd=0x8, counter +1; RSI zimm=3 old=0x8 -> data=0xB
//  CSRRC 0x304 old=0xFF rs1=0x0F -> data=0xF0; hold resp_ready=0 5 cycles -> resp/wr_* stable
//  ECALL pc=0x8000_0010 -> wr_ecall=1,en=0,plain=0,wr_pc=0x8000_0010; then MRET -> wr_mret=1
//  CSR_ILLEGAL_TRAP_EN: CSRRW 0xF14 -> resp_illegal=1, en=0; without macro en=1 data=src

Source files
------------

// File: rtl/csr_access_unit.sv
// csr_access_unit: accepts one CSR/SYSTEM instruction, reads the old CSR value,
// computes the read-modify-write result, publishes a CSR write packet and then
// returns the old value for rd.
// Optional feature macro: CSR_ILLEGAL_TRAP_EN (write intent to read-only CSR
// space, addr[11:10]==2'b11, is flagged illegal and the write is suppressed).
module csr_access_unit #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_funct3,
   input  logic [1:0]       req_sys,
   input  logic [11:0]      req_addr,
   input  logic [XLEN-1:0]  req_rs1_val,
   input  logic [4:0]       req_rs1_idx,
   input  logic [XLEN-1:0]  req_pc,
   output logic [11:0]      csr_raddr,
   input  logic [XLEN-1:0]  csr_rdata,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [XLEN-1:0]  resp_rd_data,
   output logic             resp_illegal,
   output logic [CNT_W-1:0] wr_inst_counter,
   output logic             wr_csr_write_enable,
   output logic             wr_plain,
   output logic [11:0]      wr_csr_dest_addr,
   output logic [XLEN-1:0]  wr_csr_write_data,
   output logic             wr_ecall,
   output logic             wr_mret,
   output logic [XLEN-1:0]  wr_pc
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_READ   = 2'd1,
      ST_COMMIT = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t            state_r, state_s;
   logic [2:0]        funct3_r;
   logic [1:0]        sys_r;
   logic [11:0]       addr_r;
   logic [XLEN-1:0]   rs1_val_r;
   logic [4:0]        rs1_idx_r;
   logic [XLEN-1:0]   pc_r;
   logic [XLEN-1:0]   old_r;

   logic [XLEN-1:0]   src_s;
   logic              en_s;
   logic              plain_s;
   logic [XLEN-1:0]   data_s;
   logic              ecall_s;
   logic              mret_s;
   logic [XLEN-1:0]   rd_s;
   logic              illegal_s;

   // Write intent: swap forms always write; set/clear forms only with a non-zero source index.
   function automatic logic write_intent(input logic [2:0] f3, input logic [4:0] idx);
      logic wi;
      case (f3)
         3'b001, 3'b101: wi = 1'b1;
         3'b010, 3'b011, 3'b110, 3'b111: wi = (idx != 5'd0);
         default: wi = 1'b0;
      endcase
      return wi;
   endfunction

   assign req_ready  = (state_r == ST_IDLE);
   assign resp_valid = (state_r == ST_RESP);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_s;
   end

   // Next-state logic and the CSR file read-address mux.
   always_comb begin
      state_s   = state_r;
      csr_raddr = 12'd0;
      case (state_r)
         ST_IDLE: begin
            if (req_valid) state_s = ST_READ;
            else           state_s = ST_IDLE;
         end
         ST_READ: begin
            csr_raddr = addr_r;
            state_s   = ST_COMMIT;
         end
         ST_COMMIT: state_s = ST_RESP;
         ST_RESP: begin
            if (resp_ready) state_s = ST_IDLE;
            else            state_s = ST_RESP;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Request capture in IDLE and old-value capture in READ.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         funct3_r  <= 3'd0;
         sys_r     <= 2'd0;
         addr_r    <= 12'd0;
         rs1_val_r <= {XLEN{1'b0}};
         rs1_idx_r <= 5'd0;
         pc_r      <= {XLEN{1'b0}};
         old_r     <= {XLEN{1'b0}};
      end else if (state_r == ST_IDLE && req_valid) begin
         funct3_r  <= req_funct3;
         sys_r     <= req_sys;
         addr_r    <= req_addr;
         rs1_val_r <= req_rs1_val;
         rs1_idx_r <= req_rs1_idx;
         pc_r      <= req_pc;
      end else if (state_r == ST_READ) begin
         old_r <= csr_rdata;
      end else begin
         old_r <= old_r;
      end
   end

   // Read-modify-write result and SYSTEM flags for the packet loaded at COMMIT.
   always_comb begin
      src_s     = funct3_r[2] ? XLEN'(rs1_idx_r) : rs1_val_r;
      en_s      = 1'b0;
      plain_s   = 1'b1;
      data_s    = old_r;
      ecall_s   = 1'b0;
      mret_s    = 1'b0;
      rd_s      = old_r;
      illegal_s = 1'b0;
      case (funct3_r)
         3'b001, 3'b101: begin
            en_s   = 1'b1;
            data_s = src_s;
         end
         3'b010, 3'b110: begin
            if (rs1_idx_r != 5'd0) begin
               en_s   = 1'b1;
               data_s = old_r | src_s;
            end else begin
               en_s   = 1'b0;
               data_s = old_r;
            end
         end
         3'b011, 3'b111: begin
            if (rs1_idx_r != 5'd0) begin
               en_s   = 1'b1;
               data_s = old_r & ~src_s;
            end else begin
               en_s   = 1'b0;
               data_s = old_r;
            end
         end
         3'b000: begin
            plain_s = 1'b0;
            data_s  = {XLEN{1'b0}};
            rd_s    = {XLEN{1'b0}};
            ecall_s = (sys_r == 2'b01);
            mret_s  = (sys_r == 2'b10);
         end
         default: begin
            en_s = 1'b0;
         end
      endcase
`ifdef CSR_ILLEGAL_TRAP_EN
      // Read-only CSR space: suppress the write, return 0, leave data at old value.
      if (write_intent(funct3_r, rs1_idx_r) && addr_r[11:10] == 2'b11) begin
         illegal_s = 1'b1;
         en_s      = 1'b0;
         data_s    = old_r;
         rd_s      = {XLEN{1'b0}};
      end else begin
         illegal_s = 1'b0;
      end
`else
      illegal_s = 1'b0 & write_intent(funct3_r, rs1_idx_r);
`endif
   end

   // Packet, counter and response registers, all loaded on the COMMIT edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_inst_counter     <= {CNT_W{1'b0}};
         wr_csr_write_enable <= 1'b0;
         wr_plain            <= 1'b0;
         wr_csr_dest_addr    <= 12'd0;
         wr_csr_write_data   <= {XLEN{1'b0}};
         wr_ecall            <= 1'b0;
         wr_mret             <= 1'b0;
         wr_pc               <= {XLEN{1'b0}};
         resp_rd_data        <= {XLEN{1'b0}};
         resp_illegal        <= 1'b0;
      end else if (state_r == ST_COMMIT) begin
         wr_inst_counter     <= wr_inst_counter + CNT_W'(1);
         wr_csr_write_enable <= en_s;
         wr_plain            <= plain_s;
         wr_csr_dest_addr    <= addr_r;
         wr_csr_write_data   <= data_s;
         wr_ecall            <= ecall_s;
         wr_mret             <= mret_s;
         wr_pc               <= pc_r;
         resp_rd_data        <= rd_s;
         resp_illegal        <= illegal_s;
      end else begin
         wr_inst_counter     <= wr_inst_counter;
      end
   end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed, table-driven bench for csr_access_unit.
module tb_csr_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_funct3;
   logic [1:0]  req_sys;
   logic [11:0] req_addr;
   logic [63:0] req_rs1_val;
   logic [4:0]  req_rs1_idx;
   logic [63:0] req_pc;
   logic [11:0] csr_raddr;
   logic [63:0] csr_rdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rd_data;
   logic        resp_illegal;
   logic [63:0] wr_inst_counter;
   logic        wr_csr_write_enable;
   logic        wr_plain;
   logic [11:0] wr_csr_dest_addr;
   logic [63:0] wr_csr_write_data;
   logic        wr_ecall;
   logic        wr_mret;
   logic [63:0] wr_pc;

   // Simple CSR file model: returns the vector's old value only at its address.
   logic [11:0] cur_addr;
   logic [63:0] cur_old;
   assign csr_rdata = (csr_raddr == cur_addr) ? cur_old : 64'hBADC_0FFE_E0DD_F00D;

   always #5 clk = ~clk;

   csr_access_unit dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_funct3(req_funct3), .req_sys(req_sys), .req_addr(req_addr),
      .req_rs1_val(req_rs1_val), .req_rs1_idx(req_rs1_idx), .req_pc(req_pc),
      .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_rd_data(resp_rd_data), .resp_illegal(resp_illegal),
      .wr_inst_counter(wr_inst_counter), .wr_csr_write_enable(wr_csr_write_enable),
      .wr_plain(wr_plain), .wr_csr_dest_addr(wr_csr_dest_addr),
      .wr_csr_write_data(wr_csr_write_data), .wr_ecall(wr_ecall), .wr_mret(wr_mret),
      .wr_pc(wr_pc)
   );

   typedef struct {
      logic [2:0]  funct3;
      logic [1:0]  sys;
      logic [11:0] addr;
      logic [63:0] rs1_val;
      logic [4:0]  rs1_idx;
      logic [63:0] pc;
      logic [63:0] old;
      int          hold;
      logic        exp_en;
      logic        exp_plain;
      logic [63:0] exp_data;
      logic        exp_ecall;
      logic        exp_mret;
      logic [63:0] exp_rd;
      logic        exp_ill;
   } vec_t;

   localparam int NV = 11;
   vec_t vec [NV];
   int   errors = 0;
   int   checks = 0;
   logic [63:0] exp_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   // Issue one request at a negedge and wait for the accept edge.
   task automatic issue(input vec_t v);
      @(negedge clk);
      cur_addr    = v.addr;
      cur_old     = v.old;
      req_valid   = 1'b1;
      req_funct3  = v.funct3;
      req_sys     = v.sys;
      req_addr    = v.addr;
      req_rs1_val = v.rs1_val;
      req_rs1_idx = v.rs1_idx;
      req_pc      = v.pc;
      chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      int   lat;
      v = vec[i];
      issue(v);
      chk($sformatf("v%0d raddr", i), {52'd0, csr_raddr}, {52'd0, v.addr});
      lat = 1;
      while (!resp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("v%0d latency", i), 64'(lat), 64'd3);
      exp_cnt = exp_cnt + 64'd1;
      chk($sformatf("v%0d req_ready_resp", i), {63'd0, req_ready}, 64'd0);
      chk($sformatf("v%0d counter", i), wr_inst_counter, exp_cnt);
      chk($sformatf("v%0d en", i), {63'd0, wr_csr_write_enable}, {63'd0, v.exp_en});
      chk($sformatf("v%0d plain", i), {63'd0, wr_plain}, {63'd0, v.exp_plain});
      chk($sformatf("v%0d data", i), wr_csr_write_data, v.exp_data);
      chk($sformatf("v%0d dest", i), {52'd0, wr_csr_dest_addr}, {52'd0, v.addr});
      chk($sformatf("v%0d ecall", i), {63'd0, wr_ecall}, {63'd0, v.exp_ecall});
      chk($sformatf("v%0d mret", i), {63'd0, wr_mret}, {63'd0, v.exp_mret});
      chk($sformatf("v%0d pc", i), wr_pc, v.pc);
      chk($sformatf("v%0d rd", i), resp_rd_data, v.exp_rd);
      chk($sformatf("v%0d illegal", i), {63'd0, resp_illegal}, {63'd0, v.exp_ill});
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         chk($sformatf("v%0d hold%0d valid", i, h), {63'd0, resp_valid}, 64'd1);
         chk($sformatf("v%0d hold%0d rd", i, h), resp_rd_data, v.exp_rd);
         chk($sformatf("v%0d hold%0d data", i, h), wr_csr_write_data, v.exp_data);
         chk($sformatf("v%0d hold%0d cnt", i, h), wr_inst_counter, exp_cnt);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      chk($sformatf("v%0d back_idle", i), {62'd0, resp_valid, req_ready}, 64'd1);
   endtask

   initial begin
      //            f3     sys    addr     rs1_val                 idx    pc                     old                    hold en    pl    data                    ec    mr    rd                     ill
      vec[0]  = '{3'b001, 2'b00, 12'h340, 64'hDEAD,              5'd5,  64'h100,               64'h5,                 0, 1'b1, 1'b1, 64'hDEAD,              1'b0, 1'b0, 64'h5,                 1'b0};
      vec[1]  = '{3'b010, 2'b00, 12'h300, 64'hFFFF,              5'd0,  64'h104,               64'h8,                 0, 1'b0, 1'b1, 64'h8,                 1'b0, 1'b0, 64'h8,                 1'b0};
      vec[2]  = '{3'b110, 2'b00, 12'h300, 64'h0,                 5'd3,  64'h108,               64'h8,                 0, 1'b1, 1'b1, 64'hB,                 1'b0, 1'b0, 64'h8,                 1'b0};
      vec[3]  = '{3'b011, 2'b00, 12'h304, 64'h0F,                5'd6,  64'h10C,               64'hFF,                5, 1'b1, 1'b1, 64'hF0,                1'b0, 1'b0, 64'hFF,                1'b0};
      vec[4]  = '{3'b000, 2'b01, 12'h000, 64'h0,                 5'd0,  64'h8000_0010,         64'h99,                0, 1'b0, 1'b0, 64'h0,                 1'b1, 1'b0, 64'h0,                 1'b0};
      vec[5]  = '{3'b000, 2'b10, 12'h302, 64'h0,                 5'd0,  64'h8000_0020,         64'h99,                0, 1'b0, 1'b0, 64'h0,                 1'b0, 1'b1, 64'h0,                 1'b0};
      vec[6]  = '{3'b000, 2'b00, 12'h000, 64'h0,                 5'd0,  64'h8000_0030,         64'h99,                0, 1'b0, 1'b0, 64'h0,                 1'b0, 1'b0, 64'h0,                 1'b0};
      vec[7]  = '{3'b111, 2'b00, 12'h305, 64'h0,                 5'h1F, 64'h200,               64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFE0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      vec[8]  = '{3'b101, 2'b00, 12'h341, 64'hFFFF,              5'h1A, 64'h204,               64'h1,                 0, 1'b1, 1'b1, 64'h1A,                1'b0, 1'b0, 64'h1,                 1'b0};
`ifdef CSR_ILLEGAL_TRAP_EN
      vec[9]  = '{3'b001, 2'b00, 12'hF14, 64'h1234,              5'd7,  64'h208,               64'h77,                0, 1'b0, 1'b1, 64'h77,                1'b0, 1'b0, 64'h0,                 1'b1};
`else
      vec[9]  = '{3'b001, 2'b00, 12'hF14, 64'h1234,              5'd7,  64'h208,               64'h77,                0, 1'b1, 1'b1, 64'h1234,              1'b0, 1'b0, 64'h77,                1'b0};
`endif
      vec[10] = '{3'b010, 2'b00, 12'hC00, 64'h55,                5'd0,  64'h20C,               64'h42,                0, 1'b0, 1'b1, 64'h42,                1'b0, 1'b0, 64'h42,                1'b0};

      rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
      req_funct3 = 3'd0; req_sys = 2'd0; req_addr = 12'd0;
      req_rs1_val = 64'd0; req_rs1_idx = 5'd0; req_pc = 64'd0;
      cur_addr = 12'hFFF; cur_old = 64'd0; exp_cnt = 64'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst req_ready", {63'd0, req_ready}, 64'd1);
      chk("rst resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("rst counter", wr_inst_counter, 64'd0);
      chk("rst wr_pc", wr_pc, 64'd0);

      // One op to move the counter, then reset in the middle of READ.
      run_vec(0);
      issue(vec[1]);
      chk("midread raddr", {52'd0, csr_raddr}, 64'h300);
      rst = 1'b1;
      #1;
      chk("midread async cnt", wr_inst_counter, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      chk("midread raddr0", {52'd0, csr_raddr}, 64'd0);
      chk("midread req_ready", {63'd0, req_ready}, 64'd1);
      chk("midread counter", wr_inst_counter, 64'd0);
      chk("midread en", {63'd0, wr_csr_write_enable}, 64'd0);
      chk("midread wr_data", wr_csr_write_data, 64'd0);
      chk("midread rd", resp_rd_data, 64'd0);
      repeat (4) @(negedge clk);
      chk("midread stays idle", {62'd0, resp_valid, req_ready}, 64'd1);
      exp_cnt = 64'd0;

      for (int i = 0; i < NV; i++) run_vec(i);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
